// File: rtl/token_sched_pkg.sv
// token_sched_pkg
// Shared constants and helpers for the weighted round-robin token scheduler.
//   DROP_CNT_W : width of the optional dropped-token counter
//   WEIGHT_RST : weight loaded into every channel at reset
//   ch_idx_w() : width of a channel index for an n-channel scheduler
package token_sched_pkg;

    localparam int DROP_CNT_W = 16;
    localparam int WEIGHT_RST = 1;

    function automatic int ch_idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker.
// It searches the eligible vector upward from ptr, wrapping modulo N, and
// reports the first set bit it finds.
//   elig  [N-1:0]  : eligible channels
//   ptr   [IW-1:0] : first channel to look at (must be < N)
//   grant [N-1:0]  : one-hot winner, all zeros when nothing is eligible
//   idx   [IW-1:0] : index of the winner (0 when nothing is eligible)
//   found          : a winner exists
module rr_pick
    import token_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = ch_idx_w(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // The sum is one bit wider than the index so that the wrap works for
    // channel counts that are not a power of two.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            cand = sum[IW-1:0];
            if (!found && elig[cand]) begin
                found       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/token_scheduler.sv
// token_scheduler
// Weighted round-robin scheduler for a serial stream of '1' tokens.
// Each token goes to one eligible channel (req=1 and weight!=0). The winner
// keeps the grant for weight consecutive tokens before the pointer moves on.
// Tokens with no eligible channel are dropped.
//   clk, rst_n   : clock; asynchronous active-low reset
//   a            : token input (one token per cycle with a=1)
//   req          : per-channel request
//   cfg_valid    : weight write request
//   cfg_ch       : channel index to write
//   cfg_weight   : new weight for that channel
//   cfg_ready    : write accepted this cycle (only in token-idle cycles)
//   b            : one-hot grant of the current token
//   drop         : the current token found no eligible channel
//   drop_cnt     : saturating drop counter, present only when the macro
//                  TOKEN_SCHED_DROP_CNT_EN is defined
module token_scheduler
    import token_sched_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int W_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       a,
    input  logic [N_CH-1:0]            req,
    input  logic                       cfg_valid,
    input  logic [ch_idx_w(N_CH)-1:0]  cfg_ch,
    input  logic [W_WIDTH-1:0]         cfg_weight,
    output logic                       cfg_ready,
    output logic [N_CH-1:0]            b,
`ifdef TOKEN_SCHED_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0]      drop_cnt,
`endif
    output logic                       drop
);

    localparam int IW = ch_idx_w(N_CH);

    logic [IW-1:0]      ptr_q, ptr_d;
    logic [W_WIDTH-1:0] credit_q [N_CH];
    logic [W_WIDTH-1:0] credit_d [N_CH];
    logic [W_WIDTH-1:0] weight_q [N_CH];
    logic [W_WIDTH-1:0] weight_d [N_CH];

    logic [N_CH-1:0]    elig;
    logic [N_CH-1:0]    grant;
    logic [IW-1:0]      win_idx;
    logic               found;
    logic [W_WIDTH-1:0] credit_inc;
    logic               cfg_ch_ok;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_CH; i++) begin
            elig[i] = req[i] && (weight_q[i] != '0);
        end
    end

    rr_pick #(
        .N  (N_CH),
        .IW (IW)
    ) u_pick (
        .elig  (elig),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (win_idx),
        .found (found)
    );

    // Outputs are forced low while reset is asserted, independent of a/req.
    assign b         = (rst_n && a) ? grant : '0;
    assign drop      = rst_n && a && !found;
    assign cfg_ready = rst_n && !a;

    // Out-of-range channel writes are accepted but have no effect.
    assign cfg_ch_ok = ({1'b0, cfg_ch} < (IW+1)'(N_CH));

    // Grants and config writes are mutually exclusive because config is
    // only accepted when a=0. Credits never exceed weight-1, so the
    // increment below cannot wrap.
    always_comb begin
        ptr_d      = ptr_q;
        credit_d   = credit_q;
        weight_d   = weight_q;
        credit_inc = credit_q[win_idx] + 1'b1;
        if (a && found) begin
            if (credit_inc == weight_q[win_idx]) begin
                credit_d[win_idx] = '0;
                ptr_d = (win_idx == IW'(N_CH-1)) ? '0 : win_idx + 1'b1;
            end else begin
                credit_d[win_idx] = credit_inc;
                ptr_d             = win_idx;
            end
        end else if (!a && cfg_valid && cfg_ch_ok) begin
            weight_d[cfg_ch] = cfg_weight;
            credit_d[cfg_ch] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                credit_q[i] <= '0;
                weight_q[i] <= W_WIDTH'(WEIGHT_RST);
            end
        end else begin
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            weight_q <= weight_d;
        end
    end

`ifdef TOKEN_SCHED_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_token_scheduler.sv
// tb_token_scheduler
// Self-checking bench for token_scheduler (N_CH=4, W_WIDTH=3).
// Directed scenarios followed by a randomized run against a reference model.
module tb_token_scheduler;

    localparam int N = 4;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic [3:0] req;
    logic       cfg_valid;
    logic [1:0] cfg_ch;
    logic [2:0] cfg_weight;
    logic       cfg_ready;
    logic [3:0] b;
    logic       drop;
`ifdef TOKEN_SCHED_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference state: who is being served, how many tokens it already had
    // in its current turn, and each channel's share.
    int m_ptr;
    int m_used [N];
    int m_weight [N];
    int m_drops;

    logic [3:0] exp_plan1 [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    logic [3:0] exp_plan2 [6] = '{4'h1, 4'h1, 4'h2, 4'h1, 4'h1, 4'h2};

    token_scheduler #(
        .N_CH    (4),
        .W_WIDTH (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .req        (req),
        .cfg_valid  (cfg_valid),
        .cfg_ch     (cfg_ch),
        .cfg_weight (cfg_weight),
        .cfg_ready  (cfg_ready),
        .b          (b),
`ifdef TOKEN_SCHED_DROP_CNT_EN
        .drop_cnt   (drop_cnt),
`endif
        .drop       (drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic modelReset();
        m_ptr = 0;
        for (int i = 0; i < N; i++) begin
            m_used[i]   = 0;
            m_weight[i] = 1;
        end
        m_drops = 0;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives inputs just after a posedge and moves to the mid-cycle point.
    task automatic applyStimulus(input logic ia, input logic [3:0] ireq, input logic icv,
                                 input logic [1:0] ich, input logic [2:0] iw);
        a          = ia;
        req        = ireq;
        cfg_valid  = icv;
        cfg_ch     = ich;
        cfg_weight = iw;
        #4;
    endtask

    task automatic checkLiteral(input string tag, input logic [3:0] exp);
        check(tag, {12'h0, b}, {12'h0, exp});
    endtask

    // Compares the outputs with the model, advances the model by one cycle
    // and steps to just after the next posedge.
    task automatic checkOutput(input string tag);
        int         win;
        int         c;
        logic [3:0] eb;
        logic       ed;
        win = -1;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (win < 0 && req[c] && m_weight[c] != 0) win = c;
        end
        eb = 4'h0;
        if (a && win >= 0) eb[win] = 1'b1;
        ed = a && (win < 0);
        check({tag, " b"}, {12'h0, b}, {12'h0, eb});
        check({tag, " drop"}, {15'h0, drop}, {15'h0, ed});
        check({tag, " cfg_ready"}, {15'h0, cfg_ready}, {15'h0, !a});
`ifdef TOKEN_SCHED_DROP_CNT_EN
        check({tag, " drop_cnt"}, drop_cnt, 16'(m_drops));
`endif
        if (a && win >= 0) begin
            m_used[win]++;
            if (m_used[win] == m_weight[win]) begin
                m_used[win] = 0;
                m_ptr       = (win + 1) % N;
            end else begin
                m_ptr = win;
            end
        end else if (a) begin
            if (m_drops < 65535) m_drops++;
        end else if (cfg_valid && int'(cfg_ch) < N) begin
            m_weight[cfg_ch] = int'(cfg_weight);
            m_used[cfg_ch]   = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        a          = 1'b1;
        req        = 4'hF;
        cfg_valid  = 1'b1;
        cfg_ch     = 2'd0;
        cfg_weight = 3'd0;
        modelReset();
        #3;
        check("reset b", {12'h0, b}, 16'h0);
        check("reset drop", {15'h0, drop}, 16'h0);
        check("reset cfg_ready", {15'h0, cfg_ready}, 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All weights 1, every channel requesting.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 4'hF, 1'b0, 2'd0, 3'd0);
            checkLiteral("plan1", exp_plan1[i]);
            checkOutput("plan1");
        end

        // ch0 weight 2, ch1 weight 1.
        applyStimulus(1'b0, 4'h0, 1'b1, 2'd0, 3'd2);
        checkOutput("cfg ch0=2");
        applyStimulus(1'b0, 4'h0, 1'b1, 2'd1, 3'd1);
        checkOutput("cfg ch1=1");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 4'b0011, 1'b0, 2'd0, 3'd0);
            checkLiteral("plan2", exp_plan2[i]);
            checkOutput("plan2");
        end

        // Drops: nothing requesting, then only a disabled channel requesting.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'b0000, 1'b0, 2'd0, 3'd0);
            checkOutput("drop none");
        end
        applyStimulus(1'b0, 4'h0, 1'b1, 2'd2, 3'd0);
        checkOutput("cfg ch2=0");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'b0100, 1'b0, 2'd0, 3'd0);
            checkOutput("drop w0");
        end

        // Pointer skip across idle channels with wrap back to 0.
        applyStimulus(1'b0, 4'h0, 1'b1, 2'd0, 3'd1);
        checkOutput("cfg ch0=1");
        applyStimulus(1'b1, 4'b0001, 1'b0, 2'd0, 3'd0);
        checkOutput("skip ch0");
        applyStimulus(1'b1, 4'b1001, 1'b0, 2'd0, 3'd0);
        checkLiteral("skip to ch3", 4'b1000);
        checkOutput("skip to ch3");
        applyStimulus(1'b1, 4'b1001, 1'b0, 2'd0, 3'd0);
        checkLiteral("wrap to ch0", 4'b0001);
        checkOutput("wrap to ch0");

        // Config during a token is refused, then accepted when idle.
        applyStimulus(1'b1, 4'b0000, 1'b1, 2'd2, 3'd5);
        checkOutput("cfg busy");
        applyStimulus(1'b0, 4'b0000, 1'b1, 2'd2, 3'd5);
        checkOutput("cfg idle");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 4'b0101, 1'b0, 2'd0, 3'd0);
            checkOutput("ch2 w5");
        end

        // Reset in the middle of a weighted turn.
        applyStimulus(1'b0, 4'h0, 1'b1, 2'd0, 3'd3);
        checkOutput("cfg ch0=3");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 4'b0001, 1'b0, 2'd0, 3'd0);
            checkOutput("ch0 w3");
        end
        a         = 1'b1;
        req       = 4'b0011;
        cfg_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #2;
        check("midreset b", {12'h0, b}, 16'h0);
        check("midreset drop", {15'h0, drop}, 16'h0);
        check("midreset cfg_ready", {15'h0, cfg_ready}, 16'h0);
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 4'b0011, 1'b0, 2'd0, 3'd0);
        checkLiteral("post reset 1", 4'b0001);
        checkOutput("post reset 1");
        applyStimulus(1'b1, 4'b0011, 1'b0, 2'd0, 3'd0);
        checkLiteral("post reset 2", 4'b0010);
        checkOutput("post reset 2");

        // Randomized traffic with interleaved weight writes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 4'($urandom), ($urandom_range(0, 2) == 0),
                          2'($urandom), 3'($urandom));
            checkOutput("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
